// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : shared word RAM serving iREN/dREN/dWEN with LAT wait states
// Revision      : 1.0  initial release
// ============================================================================
module mem_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_ACK  = 2'd2;

  localparam logic [1:0] c_OP_IREAD  = 2'd0;
  localparam logic [1:0] c_OP_DREAD  = 2'd1;
  localparam logic [1:0] c_OP_DWRITE = 2'd2;

  localparam logic [CW-1:0] c_LAT       = CW'(LAT);
  localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);
  // With zero wait states a captured request goes straight to the hit cycle.
  localparam logic [1:0]    c_CAP_STATE = (LAT > 0) ? c_WAIT : c_ACK;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    r_op;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          w_cap;
  logic [1:0]    w_cap_op;
  logic [AW-1:0] w_cap_idx;
  logic [31:0]   w_rdata;
  logic          w_unused;

  logic [31:0]   r_mem [DEPTH];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic, including request arbitration in IDLE
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_cap      = 1'b0;
    w_cap_op   = c_OP_IREAD;
    w_cap_idx  = iaddr[AW+1:2];
    case (r_state)
      c_IDLE: begin
        if (dREN || dWEN) begin
          w_cap     = 1'b1;
          w_cap_op  = dWEN ? c_OP_DWRITE : c_OP_DREAD;
          w_cap_idx = daddr[AW+1:2];
        end else if (iREN) begin
          w_cap     = 1'b1;
        end
        if (w_cap) begin
          w_cnt_next = c_LAT;
          w_next     = c_CAP_STATE;
        end
      end
      c_WAIT: begin
        w_cnt_next = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_next = c_ACK;
        end
      end
      c_ACK:   w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op    <= c_OP_IREAD;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_cap) begin
      r_op    <= w_cap_op;
      r_idx   <= w_cap_idx;
      r_wdata <= dstore;
    end
  end

  // Later assignment wins: an ACK write beats a same-index preload.
  always_ff @(posedge CLK) begin
    if (ld_en) begin
      r_mem[ld_addr[AW+1:2]] <= ld_data;
    end
    if (!RST && (r_state == c_ACK) && (r_op == c_OP_DWRITE)) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign w_rdata = r_mem[r_idx];

  // Output logic
  always_comb begin
    ihit  = 1'b0;
    dhit  = 1'b0;
    iload = '0;
    dload = '0;
    if (r_state == c_ACK) begin
      case (r_op)
        c_OP_IREAD: begin
          ihit  = 1'b1;
          iload = w_rdata;
        end
        c_OP_DREAD: begin
          dhit  = 1'b1;
          dload = w_rdata;
        end
        c_OP_DWRITE: dhit = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_unused = ^{iaddr[31:AW+2], iaddr[1:0], daddr[31:AW+2], daddr[1:0],
                      ld_addr[31:AW+2], ld_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// tb_mem_responder : directed + randomized checks against an array-based model
module tb_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, iREN, dREN, dWEN, ld_en, ihit, dhit;
  logic [31:0] iaddr, daddr, dstore, ld_addr, ld_data, iload, dload;
  logic        iREN_z, dREN_z, dWEN_z, ld_en_z, ihit_z, dhit_z;
  logic [31:0] iaddr_z, daddr_z, dstore_z, ld_addr_z, ld_data_z, iload_z, dload_z;

  mem_responder #(.DEPTH(DEPTH), .LAT(LAT)) u_dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ihit(ihit), .iload(iload), .dhit(dhit),
    .dload(dload), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  mem_responder #(.DEPTH(DEPTH), .LAT(0)) u_dut_z (
    .CLK(CLK), .RST(RST), .iREN(iREN_z), .iaddr(iaddr_z), .dREN(dREN_z), .dWEN(dWEN_z),
    .daddr(daddr_z), .dstore(dstore_z), .ihit(ihit_z), .iload(iload_z), .dhit(dhit_z),
    .dload(dload_z), .ld_en(ld_en_z), .ld_addr(ld_addr_z), .ld_data(ld_data_z)
  );

  logic [31:0] model [DEPTH];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd4) % DEPTH);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {30'b0, ihit, dhit, iload | dload}, 64'd0);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
    model[idx_of(a)] = d;
  endtask

  // op: 0 ifetch, 1 data read, 2 data write, 3 dREN+dWEN (write wins)
  task automatic txn(input int op, input logic [31:0] a, input logic [31:0] wd, input bit clash);
    bit          wr;
    logic [31:0] exp_i, exp_d;
    wr    = (op >= 2);
    exp_i = (op == 0) ? model[idx_of(a)] : 32'd0;
    exp_d = (op == 1) ? model[idx_of(a)] : 32'd0;
    iREN = (op == 0); dREN = (op == 1 || op == 3); dWEN = wr;
    iaddr = a; daddr = a; dstore = wd;
    step();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = $urandom; daddr = $urandom; dstore = $urandom;
    for (int k = 1; k <= LAT; k++) begin
      idle_chk("wait_nohit");
      step();
    end
    chk("hit", {62'b0, ihit, dhit}, (op == 0) ? 64'd2 : 64'd1);
    chk("load", {iload, dload}, {exp_i, exp_d});
    if (clash && wr) begin
      ld_en = 1'b1; ld_addr = a; ld_data = ~wd;
    end
    step();
    ld_en = 1'b0;
    if (wr) model[idx_of(a)] = wd;
    idle_chk("post_ack");
  endtask

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ld_en = 0;
    iaddr = 0; daddr = 0; dstore = 0; ld_addr = 0; ld_data = 0;
    iREN_z = 0; dREN_z = 0; dWEN_z = 0; ld_en_z = 0;
    iaddr_z = 0; daddr_z = 0; dstore_z = 0; ld_addr_z = 0; ld_data_z = 0;
    step();
    step();
    idle_chk("reset_a");
    chk("reset_z", {30'b0, ihit_z, dhit_z, iload_z | dload_z}, 64'd0);
    RST = 1'b0;

    for (int i = 0; i < DEPTH; i++) preload(32'(i * 4), $urandom);

    // Instruction fetch latency and data
    preload(32'h40, 32'h3C01DEAD);
    txn(0, 32'h40, 0, 0);

    // Write then read with ignored low address bits
    txn(2, 32'h80, 32'h12345678, 0);
    txn(1, 32'h83, 0, 0);

    // Simultaneous iREN + dREN, each held until its own hit
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h40; daddr = 32'h80;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      chk("arb_hits", {62'b0, ihit, dhit}, {62'b0, cyc == 7, cyc == 3});
      if (cyc == 3) begin
        chk("arb_dload", {32'b0, dload}, {32'b0, model[idx_of(32'h80)]});
        dREN = 1'b0;
      end
      if (cyc == 7) begin
        chk("arb_iload", {32'b0, iload}, {32'b0, model[idx_of(32'h40)]});
        iREN = 1'b0;
      end
    end

    // Reset abandons an in-flight write
    preload(32'h100, 32'hAAAA5555);
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h11112222;
    step();
    dWEN = 1'b0;
    idle_chk("rst_wait1");
    step();
    RST = 1'b1;
    idle_chk("rst_wait2");
    step();
    RST = 1'b0;
    idle_chk("rst_nohit");
    step();
    idle_chk("rst_idle");
    txn(1, 32'h100, 0, 0);

    // Zero wait states, request held continuously
    ld_en_z = 1'b1; ld_addr_z = 32'h10; ld_data_z = 32'h5A5A0F0F;
    step();
    ld_en_z = 1'b0;
    dREN_z = 1'b1; daddr_z = 32'h10;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      chk("lat0_hit", {62'b0, ihit_z, dhit_z}, {63'b0, cyc % 2 == 1});
      chk("lat0_dload", {32'b0, dload_z}, (cyc % 2 == 1) ? 64'h5A5A0F0F : 64'd0);
    end
    dREN_z = 1'b0;

    // Address wrap modulo DEPTH
    preload(32'h4, 32'hCAFEF00D);
    txn(1, 32'h1004, 0, 0);

    // Same-cycle preload vs ACK write to the same index
    txn(2, 32'h200, 32'h0BADBEEF, 1);
    txn(1, 32'h200, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) preload($urandom, $urandom);
      txn(int'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's instruction-fetch and data-memory requests, i.e. the far end of the iREN/dREN/dWEN request lines the decoder drives.
- Arbitrates one shared word-addressed RAM between the instruction and data ports.
- Inserts a programmable number of wait states, then returns a single-cycle hit with read data.
- Includes a preload port so benches can load program images before releasing the core.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM (power of two)
LAT, 2, wait-state cycles between request capture and hit (0 allowed)

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  synchronous active-high reset
iREN  in  1  instruction read request
iaddr  in  32  instruction byte address
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  32  data byte address
dstore  in  32  data write value
ihit  out  1  instruction request complete (one-cycle pulse)
iload  out  32  instruction word, valid with ihit, else 0
dhit  out  1  data request complete (one-cycle pulse)
dload  out  32  data read word, valid with dhit on reads, else 0
ld_en  in  1  preload write enable
ld_addr  in  32  preload byte address
ld_data  in  32  preload word

Behaviour:
- Word index = addr[log2(DEPTH)+1:2]. Bits [1:0] are ignored. Higher bits are dropped, so the index wraps modulo DEPTH.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If dREN|dWEN: latch daddr, dstore, op = DREAD or DWRITE. dWEN wins when dREN and dWEN are both high.
  - Else if iREN: latch iaddr, op = IREAD.
  - Else stay in IDLE.
  - On capture: counter <= LAT. Next state is WAIT if LAT > 0, else ACK.
- WAIT: counter decrements each cycle. When counter reaches 1, the next state is ACK.
- Latency: a request sampled in IDLE at edge N produces its hit in cycle N+LAT+1.
- ACK:
  - Assert the matching hit for exactly one cycle.
  - IREAD: iload = RAM[idx].
  - DREAD: dload = RAM[idx].
  - DWRITE: RAM[idx] <= latched dstore at the ACK edge; dload = 0.
  - Next state is always IDLE.
- Read data is RAM contents during the ACK cycle, so any earlier write to that index is visible.
- Requests are latched at capture. Deasserting a request or changing address/data during WAIT has no effect; the transaction completes and hits.
- A request still held in IDLE after ACK is a new transaction (back-to-back). The requester drops its request on hit to avoid repeats.
- Arbitration: data always beats instruction in IDLE. A waiting iREN is served at the next IDLE in which no data request is present.
- Preload:
  - ld_en writes ld_data to RAM[ld_addr index] on any cycle, in any state.
  - If an ACK DWRITE targets the same index in the same cycle, the DWRITE value wins.
- Reset:
  - RST high at an edge forces IDLE and counter = 0.
  - Next cycle: ihit = dhit = 0, iload = dload = 0.
  - An in-flight transaction is abandoned: no hit, and no write for a pending DWRITE.
  - RAM contents are not cleared by RST.
- Outputs are registered off state: hit only in ACK, load buses zero outside ACK.

Test Plan:
1. LAT=2. Preload 0x00000040 = 0x3C01DEAD. Pulse iREN, iaddr=0x40, at edge 0 -> ihit=1, iload=0x3C01DEAD in cycle 3 only; ihit=0 in cycles 1, 2, 4.
2. dWEN, daddr=0x80, dstore=0x12345678 -> dhit in cycle 3, dload=0. Then dREN, daddr=0x83 -> dhit in cycle 7, dload=0x12345678 (bits [1:0] ignored).
3. iREN and dREN asserted together at edge 0 and held until their own hits -> dhit in cycle 3, then ihit in cycle 7; never both in one cycle.
4. RST pulsed in cycle 2 during a DWRITE to 0x100 (old value 0xAAAA5555) -> no dhit, state IDLE; a subsequent read of 0x100 returns 0xAAAA5555.
5. LAT=0 with dREN held continuously on 0x10 -> dhit in cycles 1, 3, 5... (every other cycle) with constant dload.
6. DEPTH=1024. Preload 0x00000004 = 0xCAFEF00D, then read address 0x00001004 -> dload=0xCAFEF00D (wrap).
